// File: rtl/eyeriss_pkg.sv
// eyeriss_pkg: shared PE mode encoding and scratchpad width helpers
package eyeriss_pkg;
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_DATA = 2'b01;
  localparam logic [1:0] MODE_MULT = 2'b10;
  localparam logic [1:0] MODE_ACCU = 2'b11;
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction
  function automatic int adr_w(input int max_len);
    return $clog2(max_len);
  endfunction
endpackage

// File: rtl/eyeriss_win_iter.sv
// eyeriss_win_iter: self-wrapping (o,k) window counter, k inner; sum_adr = o+k
// ports: clk/reset, clr/en, k_len/o_len (1..MAX_LEN), o_adr/k_adr/sum_adr, last
module eyeriss_win_iter #(
  parameter int LEN_W = 5,
  parameter int ADR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [LEN_W-1:0] k_len,
  input  logic [LEN_W-1:0] o_len,
  output logic [ADR_W-1:0] o_adr,
  output logic [ADR_W-1:0] k_adr,
  output logic [ADR_W-1:0] sum_adr,
  output logic             last
);
  logic [LEN_W-1:0] o, k;
  logic k_end, o_end;
  assign k_end   = k == k_len - 1'b1;
  assign o_end   = o == o_len - 1'b1;
  assign last    = k_end && o_end;
  assign o_adr   = o[ADR_W-1:0];
  assign k_adr   = k[ADR_W-1:0];
  assign sum_adr = ADR_W'(o + k);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      o <= '0;
      k <= '0;
    end else if (clr) begin
      o <= '0;
      k <= '0;
    end else if (en) begin
      k <= k_end ? '0 : k + 1'b1;
      o <= k_end ? (o_end ? '0 : o + 1'b1) : o;
    end
endmodule

// File: rtl/eyeriss_pe_ctrl_v2.sv
// eyeriss_pe_ctrl_v2: row-stationary PE controller (load, 1-D conv MULT, psum drain)
// ports: cfg_* configuration in IDLE; stall freezes everything; fil/map valid-ready load
// streams with scratchpad we/addr; mac_en/acc_clr/psum_addr drive the MAC; psum_in/psum_out
// handshakes in ACCU; mode/psum_src/busy/done/cfg_err status.
module eyeriss_pe_ctrl_v2 import eyeriss_pkg::*; #(
  parameter int MAX_LEN = 16,
  parameter int CH_W    = 4,
  parameter int LEN_W   = len_w(MAX_LEN),
  parameter int ADR_W   = adr_w(MAX_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [LEN_W-1:0] cfg_filt_len,
  input  logic [LEN_W-1:0] cfg_map_len,
  input  logic [CH_W-1:0]  cfg_channels,
  input  logic             cfg_psum_src,
  input  logic             stall,
  input  logic             fil_valid,
  output logic             fil_ready,
  input  logic             map_valid,
  output logic             map_ready,
  output logic             fil_we,
  output logic             map_we,
  output logic [ADR_W-1:0] fil_addr,
  output logic [ADR_W-1:0] map_addr,
  output logic [ADR_W-1:0] psum_addr,
  output logic             mac_en,
  output logic             acc_clr,
  input  logic             psum_in_valid,
  output logic             psum_in_ready,
  output logic             psum_out_valid,
  input  logic             psum_out_ready,
  output logic [1:0]       mode,
  output logic             psum_src,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  logic [1:0]       state;
  logic [LEN_W-1:0] f_len, m_len, fcnt, mcnt, nout, k_len;
  logic [CH_W-1:0]  ch_max, channel;
  logic [ADR_W-1:0] o_adr, k_adr, sum_adr;
  logic cfg_bad, load_done, out_fire, it_last, it_en, more_ch;
  assign cfg_bad = cfg_filt_len == '0 || cfg_map_len == '0 || cfg_filt_len > cfg_map_len ||
                   cfg_filt_len > LEN_W'(MAX_LEN) || cfg_map_len > LEN_W'(MAX_LEN);
  assign nout      = m_len - f_len + 1'b1;
  assign load_done = fcnt == f_len && mcnt == m_len;
  assign more_ch   = channel < ch_max;
  assign fil_ready = state == MODE_DATA && !stall && fcnt < f_len;
  assign map_ready = state == MODE_DATA && !stall && mcnt < m_len;
  assign fil_we    = fil_valid && fil_ready;
  assign map_we    = map_valid && map_ready;
  assign mac_en    = state == MODE_MULT && !stall;
  assign acc_clr   = state == MODE_MULT && channel == '0 && k_adr == '0;
  assign psum_out_valid = state == MODE_ACCU && !stall && psum_in_valid;
  assign out_fire       = psum_out_valid && psum_out_ready;
  assign psum_in_ready  = out_fire;
  // ACCU reuses the window counter with a single-tap inner loop so o steps once per fire
  assign k_len     = state == MODE_ACCU ? LEN_W'(1) : f_len;
  assign it_en     = mac_en || out_fire;
  assign done      = out_fire && it_last;
  assign mode      = state;
  assign busy      = state != MODE_IDLE;
  assign fil_addr  = state == MODE_DATA ? fcnt[ADR_W-1:0] : state == MODE_MULT ? k_adr : '0;
  assign map_addr  = state == MODE_DATA ? mcnt[ADR_W-1:0] : state == MODE_MULT ? sum_adr : '0;
  assign psum_addr = state[1] ? o_adr : '0;
  eyeriss_win_iter #(.LEN_W(LEN_W), .ADR_W(ADR_W)) u_iter (
    .clk(clk), .reset(reset), .clr(state == MODE_IDLE), .en(it_en),
    .k_len(k_len), .o_len(nout), .o_adr(o_adr), .k_adr(k_adr), .sum_adr(sum_adr),
    .last(it_last)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= MODE_IDLE;
      f_len    <= '0;
      m_len    <= '0;
      ch_max   <= '0;
      channel  <= '0;
      fcnt     <= '0;
      mcnt     <= '0;
      psum_src <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (!stall)
        case (state)
          MODE_IDLE: if (cfg_valid) begin
            f_len    <= cfg_filt_len;
            m_len    <= cfg_map_len;
            ch_max   <= cfg_channels;
            psum_src <= cfg_psum_src;
            cfg_err  <= cfg_bad;
            state    <= cfg_bad ? MODE_IDLE : MODE_DATA;
            channel  <= '0;
            fcnt     <= '0;
            mcnt     <= '0;
          end
          MODE_DATA: if (load_done) begin
            state <= MODE_MULT;
            fcnt  <= '0;
            mcnt  <= '0;
          end else begin
            fcnt <= fcnt + LEN_W'(fil_we);
            mcnt <= mcnt + LEN_W'(map_we);
          end
          MODE_MULT: if (it_last) begin
            state   <= more_ch ? MODE_DATA : MODE_ACCU;
            channel <= more_ch ? channel + 1'b1 : channel;
          end
          default: if (done) state <= MODE_IDLE;
        endcase
    end
endmodule

// File: tb/tb_eyeriss_pe_ctrl_v2.sv
// tb_eyeriss_pe_ctrl_v2: directed self-checking bench for eyeriss_pe_ctrl_v2
module tb_eyeriss_pe_ctrl_v2;
  logic clk = 1'b0, reset, cfg_valid, cfg_psum_src, stall;
  logic [4:0] cfg_filt_len, cfg_map_len;
  logic [3:0] cfg_channels;
  logic fil_valid, fil_ready, map_valid, map_ready, fil_we, map_we;
  logic [3:0] fil_addr, map_addr, psum_addr;
  logic mac_en, acc_clr, psum_in_valid, psum_in_ready, psum_out_valid, psum_out_ready;
  logic [1:0] mode;
  logic psum_src, busy, done, cfg_err;
  int checks = 0, failures = 0;

  eyeriss_pe_ctrl_v2 dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_filt_len(cfg_filt_len),
    .cfg_map_len(cfg_map_len), .cfg_channels(cfg_channels), .cfg_psum_src(cfg_psum_src),
    .stall(stall), .fil_valid(fil_valid), .fil_ready(fil_ready), .map_valid(map_valid),
    .map_ready(map_ready), .fil_we(fil_we), .map_we(map_we), .fil_addr(fil_addr),
    .map_addr(map_addr), .psum_addr(psum_addr), .mac_en(mac_en), .acc_clr(acc_clr),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .mode(mode),
    .psum_src(psum_src), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic start(input int f, input int m, input int c, input logic src);
    fil_valid = 1'b1;
    map_valid = 1'b1;
    psum_in_valid = 1'b0;
    psum_out_ready = 1'b1;
    cfg_filt_len = 5'(f);
    cfg_map_len = 5'(m);
    cfg_channels = 4'(c);
    cfg_psum_src = src;
    cfg_valid = 1'b1;
    step;
    cfg_valid = 1'b0;
    #1;
    chk("cfg_mode", mode, 1);
    chk("cfg_busy", busy, 1);
    chk("cfg_src", psum_src, src);
    chk("cfg_err_ok", cfg_err, 0);
  endtask

  task automatic load(input int f, input int m);
    int fw = 0, mw = 0;
    for (int n = 0; n < 64 && mode == 2'd1; n++) begin
      if (fil_we) begin
        chk("load_faddr", fil_addr, fw);
        fw++;
      end
      if (map_we) begin
        chk("load_maddr", map_addr, mw);
        mw++;
      end
      step;
    end
    chk("load_fil_cnt", fw, f);
    chk("load_map_cnt", mw, m);
  endtask

  task automatic mult(input int f, input int m, input int sidx, input bit first);
    int cyc = 0, clrs = 0;
    for (int n = 0; n < 300 && mode == 2'd2; n++) begin
      if (cyc == sidx) begin
        stall = 1'b1;
        repeat (3) begin
          #1;
          chk("stall_mac", mac_en, 0);
          chk("stall_maddr", map_addr, cyc / f + cyc % f);
          chk("stall_paddr", psum_addr, cyc / f);
          chk("stall_mode", mode, 2);
          step;
        end
        stall = 1'b0;
        sidx = -1;
        #1;
      end
      chk("mult_mac", mac_en, 1);
      chk("mult_faddr", fil_addr, cyc % f);
      chk("mult_maddr", map_addr, cyc / f + cyc % f);
      chk("mult_paddr", psum_addr, cyc / f);
      chk("mult_clr", acc_clr, first && cyc % f == 0);
      clrs += int'(acc_clr);
      cyc++;
      step;
    end
    chk("mult_cycles", cyc, (m - f + 1) * f);
    chk("mult_clr_cnt", clrs, first ? m - f + 1 : 0);
  endtask

  task automatic accu(input int nout, input int gap);
    int fires = 0;
    psum_out_ready = 1'b1;
    psum_in_valid = 1'b0;
    #1;
    for (int i = 0; i < gap; i++) begin
      chk("gap_valid", psum_out_valid, 0);
      chk("gap_ready", psum_in_ready, 0);
      chk("gap_paddr", psum_addr, 0);
      chk("gap_mode", mode, 3);
      step;
    end
    psum_in_valid = 1'b1;
    #1;
    for (int n = 0; n < 64 && mode == 2'd3; n++) begin
      chk("accu_valid", psum_out_valid, 1);
      chk("accu_in_ready", psum_in_ready, 1);
      chk("accu_paddr", psum_addr, fires);
      chk("accu_done", done, fires == nout - 1);
      fires++;
      step;
    end
    psum_in_valid = 1'b0;
    chk("accu_fires", fires, nout);
    chk("accu_idle", busy, 0);
    chk("accu_done_low", done, 0);
  endtask

  task automatic run(input int f, input int m, input int c, input logic src, input int sidx,
                     input int gap);
    start(f, m, c, src);
    for (int p = 0; p <= c; p++) begin
      load(f, m);
      mult(f, m, p == 0 ? sidx : -1, p == 0);
      chk("pass_next", mode, p < c ? 1 : 3);
    end
    accu(m - f + 1, gap);
  endtask

  initial begin
    reset = 1'b1;
    {cfg_valid, cfg_psum_src, stall, fil_valid, map_valid, psum_in_valid, psum_out_ready} = '0;
    cfg_filt_len = '0;
    cfg_map_len = '0;
    cfg_channels = '0;
    repeat (2) step;
    chk("rst_mode", mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {fil_ready, map_ready, mac_en, acc_clr, psum_out_valid, done, cfg_err,
                     psum_src}, 0);
    chk("rst_addrs", {fil_addr, map_addr, psum_addr}, 0);
    reset = 1'b0;
    step;
    run(3, 5, 0, 1'b0, -1, 0);
    run(2, 4, 1, 1'b1, -1, 0);
    run(1, 1, 0, 1'b0, -1, 0);
    cfg_filt_len = 5'd5;
    cfg_map_len = 5'd3;
    cfg_valid = 1'b1;
    step;
    cfg_valid = 1'b0;
    #1;
    chk("bad_err", cfg_err, 1);
    chk("bad_busy", busy, 0);
    step;
    chk("bad_pulse", cfg_err, 0);
    cfg_filt_len = 5'd0;
    cfg_valid = 1'b1;
    step;
    cfg_valid = 1'b0;
    #1;
    chk("zero_err", cfg_err, 1);
    chk("zero_busy", busy, 0);
    step;
    run(3, 5, 0, 1'b0, 4, 0);
    run(3, 5, 0, 1'b1, -1, 4);
    start(3, 5, 0, 1'b0);
    load(3, 5);
    mult(3, 5, -1, 1'b1);
    psum_in_valid = 1'b1;
    psum_out_ready = 1'b1;
    #1;
    chk("abort_paddr0", psum_addr, 0);
    step;
    chk("abort_paddr1", psum_addr, 1);
    reset = 1'b1;
    #1;
    chk("abort_mode", mode, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_outs", {psum_out_valid, psum_in_ready, psum_addr, psum_src}, 0);
    step;
    reset = 1'b0;
    psum_in_valid = 1'b0;
    step;
    run(2, 3, 0, 1'b0, -1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eyeriss_pe_ctrl_v2.md
Name: eyeriss_pe_ctrl_v2

Overview:
Parametrised next-generation controller for one row-stationary Eyeriss PE. It sequences filter/ifmap loading, a sliding-window 1-D convolution of F taps over M map entries, and multi-channel psum accumulation. It then drains NOUT = M-F+1 psums, optionally adding the psum arriving from the neighbouring PE or the GLB. It drives the PE datapath scratchpads and MAC, and replaces the fixed-16-entry, single-channel, clock-skipping controller with a one-MAC-per-cycle schedule and valid/ready handshakes.

Parameters:
MAX_LEN, 16, maximum filter and map scratchpad depth (>=2)
CH_W, 4, width of the channel-count field (up to 2^CH_W channels)
LEN_W, $clog2(MAX_LEN)+1, derived width of length fields (encodes 1..MAX_LEN)
ADR_W, $clog2(MAX_LEN), derived scratchpad address width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  configuration strobe, sampled only in IDLE
cfg_filt_len  in  LEN_W  F, number of filter taps
cfg_map_len  in  LEN_W  M, number of ifmap entries per channel
cfg_channels  in  CH_W  C-1, number of channel passes minus one
cfg_psum_src  in  1  0: psum_in from PE neighbour, 1: from GLB (datapath mux select, also output)
stall  in  1  freeze request
fil_valid/fil_ready  in/out  1  filter word handshake
map_valid/map_ready  in/out  1  ifmap word handshake
fil_we/map_we  out  1  scratchpad write enables (= fire of each handshake)
fil_addr/map_addr  out  ADR_W  scratchpad addresses (write in LOAD, read in MULT)
psum_addr  out  ADR_W  local psum index
mac_en  out  1  MAC enable
acc_clr  out  1  MAC overwrites rather than accumulates psum_addr
psum_in_valid/psum_in_ready  in/out  1  incoming psum handshake (ACCU)
psum_out_valid/psum_out_ready  out/in  1  outgoing psum handshake (ACCU)
mode  out  2  00 IDLE, 01 DATA(LOAD), 10 MULT, 11 ACCU
psum_src  out  1  registered cfg_psum_src
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on final psum transfer
cfg_err  out  1  one-cycle pulse on rejected configuration

Behaviour:
- Reset: state IDLE, all counters 0, every output 0.
- IDLE: on cfg_valid, latch all cfg fields. If F==0, M==0, F>M, or either length >MAX_LEN -> cfg_err=1 next cycle, stay IDLE. Else -> LOAD, channel=0. cfg_valid outside IDLE is ignored.
- LOAD: fil_ready=(fcnt<F), map_ready=(mcnt<M); both streams proceed concurrently. Fire increments the count; address = count before increment. When both counts are complete (registered) -> MULT next cycle; counts clear.
- MULT: nested counters o in 0..NOUT-1 (outer) and k in 0..F-1 (inner); one MAC per cycle, no skipped cycles. fil_addr=k, map_addr=o+k, psum_addr=o, mac_en=1, acc_clr=(channel==0 && k==0). Duration exactly NOUT*F cycles. After the last (o,k): channel<C-1 -> channel+1, LOAD; else -> ACCU. The psum scratchpad is retained across passes.
- ACCU: index o=0..NOUT-1, psum_addr=o. psum_out_valid = (psum_in_valid || cfg is single-PE? no) psum_in_valid. psum_in_ready = psum_out_ready && psum_out_valid. o advances on psum_out fire. Last fire -> done=1, -> IDLE.
- stall (highest priority after reset): state and all counters hold; mac_en, fil_we, map_we, all ready/valid outputs forced 0; mode/addresses hold. No transfer occurs in a cycle where stall=1 even if the partner is valid. Releasing stall resumes the exact position.
- Simultaneous last LOAD fire and stall: the fire is blocked and LOAD is repeated after stall.
- F==M: NOUT=1. F==1: k fixed 0, acc_clr each output on channel 0.
- Widths: o+k <= M-1 always; counters are ADR_W+1 bits internally to hold the terminal compare.
- Reset mid-operation aborts immediately; no done pulse.

Decomposition:
- Shared package eyeriss_pkg: mode/state encoding (IDLE/DATA/MULT/ACCU = 00/01/10/11, same as existing PE modes), LEN_W/ADR_W derivation functions.
- One sub-module: eyeriss_win_iter, the (o,k) nested counter with enable/clear, last-flag, and o+k address output. It is reused by the future 2-D controller.

Test Plan:
- F=3, M=5, C=0, no stall: 5 map + 3 filter writes -> MULT 9 cycles, map_addr 0,1,2,1,2,3,2,3,4; acc_clr at cycles 0,3,6; 3 psum_out fires then done.
- F=2, M=4, C=1: LOAD-MULT-LOAD-MULT-ACCU; acc_clr high only in first pass (3 pulses); second MULT 6 cycles with acc_clr=0.
- F=M=1, C=0: 1 MULT cycle, acc_clr=1, one output; cfg F=5 M=3 -> cfg_err pulse, busy stays 0.
- stall for 3 cycles at MULT o=1,k=1 (F=3,M=5): mac_en=0 and addresses frozen; total mac_en-high cycles still 9.
- ACCU with psum_in_valid low 4 cycles while psum_out_ready=1: psum_out_valid=0, o held; then 3 transfers, done.
- Assert reset during ACCU o=1: all outputs 0 asynchronously, busy=0, no done; new config runs normally.
